// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bundle of the requester handshake and the shared 32x8
//               synchronous memory port seen by mem_arbiter.
//               'slave' is the arbiter's view; 'master' is the environment
//               view (requesters plus the memory that returns read data).
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int AW      = 5,
  parameter int DW      = 8
);

  // Requester side
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    req_we;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_wdata;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [DW-1:0]         rsp_rdata;
  logic                  busy;

  // Memory side
  logic                  mem_read;
  logic                  mem_write;
  logic [AW-1:0]         mem_addr;
  logic [DW-1:0]         mem_data_in;
  logic [DW-1:0]         mem_data_out;

  // Arbiter view
  modport slave (
    input  req, req_we, req_addr, req_wdata, mem_data_out,
    output gnt, rsp_valid, rsp_rdata, busy,
    output mem_read, mem_write, mem_addr, mem_data_in
  );

  // Environment view: requesters and the memory model
  modport master (
    output req, req_we, req_addr, req_wdata, mem_data_out,
    input  gnt, rsp_valid, rsp_rdata, busy,
    input  mem_read, mem_write, mem_addr, mem_data_in
  );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one synchronous memory port among NUM_REQ requesters.
//               One access per grant, fixed strobe sequence:
//                 write : IDLE -> ACCESS -> DONE             (3 cycles)
//                 read  : IDLE -> ACCESS -> CAPTURE -> DONE  (4 cycles)
//               Build option: define MEM_ARB_RR_EN for round-robin
//               arbitration; otherwise fixed priority (lowest index wins).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int AW      = 5,
  parameter int DW      = 8
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus_if
);

  localparam int                 C_IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] C_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]      rsp_rdata_q, rsp_rdata_d;
  logic               mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d;
  logic [AW-1:0]      mem_addr_q, mem_addr_d;
  logic [DW-1:0]      mem_wdata_q, mem_wdata_d;
  logic [C_IW-1:0]    sel_q, sel_d;      // requester owning the current access
  logic               we_q, we_d;        // current access is a write

`ifdef MEM_ARB_RR_EN
  localparam logic [C_IW-1:0] C_LAST_RST = C_IW'(NUM_REQ - 1);
  logic [C_IW-1:0]    last_q, last_d;    // index of the most recent grant
`endif

  logic               w_any_req;
  logic [C_IW-1:0]    w_win;
  logic               w_win_we;
  logic [AW-1:0]      w_win_addr;
  logic [DW-1:0]      w_win_wdata;

`ifdef MEM_ARB_RR_EN
  // Round-robin winner: first requester at or after last+1, wrapping
  always_comb begin
    w_win     = '0;
    w_any_req = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!w_any_req && bus_if.req[j] &&
            (((int'(last_q) + k) % NUM_REQ) == j)) begin
          w_any_req = 1'b1;
          w_win     = C_IW'(j);
        end
      end
    end
  end
`else
  // Fixed-priority winner: lowest asserted index
  always_comb begin
    w_win     = '0;
    w_any_req = |bus_if.req;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (bus_if.req[j]) begin
        w_win = C_IW'(j);
      end
    end
  end
`endif

  // Route the winner's command fields to the capture registers
  always_comb begin
    w_win_we    = 1'b0;
    w_win_addr  = '0;
    w_win_wdata = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_win == C_IW'(j)) begin
        w_win_we    = bus_if.req_we[j];
        w_win_addr  = bus_if.req_addr[j*AW +: AW];
        w_win_wdata = bus_if.req_wdata[j*DW +: DW];
      end
    end
  end

  // Sequencer next state; strobes and pulses default low, data holds
  always_comb begin
    state_d     = state_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    sel_d       = sel_q;
    we_d        = we_q;
`ifdef MEM_ARB_RR_EN
    last_d      = last_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // The command is captured here; later changes on the requester
        // bus cannot affect the access in flight.
        if (w_any_req) begin
          gnt_d       = C_ONE << w_win;
          sel_d       = w_win;
          we_d        = w_win_we;
          mem_addr_d  = w_win_addr;
          mem_wdata_d = w_win_wdata;
          mem_write_d = w_win_we;
          mem_read_d  = ~w_win_we;
`ifdef MEM_ARB_RR_EN
          last_d      = w_win;
`endif
          state_d     = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        // Memory samples the strobe at the end of this cycle
        if (we_q) begin
          rsp_valid_d = C_ONE << sel_q;
          state_d     = ST_DONE;
        end else begin
          state_d     = ST_CAPTURE;
        end
      end

      ST_CAPTURE: begin
        // Read data from the memory is valid in this cycle
        rsp_rdata_d = bus_if.mem_data_out;
        rsp_valid_d = C_ONE << sel_q;
        state_d     = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_q      <= C_LAST_RST;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
`ifdef MEM_ARB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  assign bus_if.gnt         = gnt_q;
  assign bus_if.rsp_valid   = rsp_valid_q;
  assign bus_if.rsp_rdata   = rsp_rdata_q;
  assign bus_if.busy        = (state_q != ST_IDLE);
  assign bus_if.mem_read    = mem_read_q;
  assign bus_if.mem_write   = mem_write_q;
  assign bus_if.mem_addr    = mem_addr_q;
  assign bus_if.mem_data_in = mem_wdata_q;

`ifndef SYNTHESIS
  a_strobe_excl: assert property (@(posedge clk) disable iff (reset)
    !(mem_read_q && mem_write_q));
  a_gnt_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(gnt_q));
  a_rsp_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(rsp_valid_q));
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter with a 32x8 synchronous
//               memory model. Grants are predicted from the request vector,
//               responses are matched against a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int NUM_REQ = 4;
  localparam int AW      = 5;
  localparam int DW      = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_if (bus.slave)
  );

  // 32x8 synchronous memory: read data valid the cycle after mem_read
  logic [DW-1:0] mem [32];
  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.mem_addr] = bus.mem_data_in;
    if (bus.mem_read) bus.mem_data_out <= mem[bus.mem_addr];
  end

  typedef struct {
    int            id;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } vec_t;

  typedef struct {
    int            id;
    bit            we;
    logic [DW-1:0] rdata;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  vec_t          vt[9];
  int            checks   = 0;
  int            failures = 0;
  int            cyc      = 0;
  int            last_m   = NUM_REQ - 1;
  logic [DW-1:0] last_rd  = '0;
  bit            we_a    [NUM_REQ];
  logic [AW-1:0] addr_a  [NUM_REQ];
  logic [DW-1:0] wdata_a [NUM_REQ];
  logic [DW-1:0] exp_a   [NUM_REQ];
  int            again   [NUM_REQ];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] pre(input int a);
    return 8'(a * 7 + 3);
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input int id);
    logic [NUM_REQ-1:0] v;
    v = '0;
    if (id >= 0 && id < NUM_REQ) v[id] = 1'b1;
    return v;
  endfunction

  // Expected winner for a sampled request vector
  function automatic int pick(input logic [NUM_REQ-1:0] r, input int last);
`ifdef MEM_ARB_RR_EN
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (r[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
`else
    if (last < 0) return -1;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (r[j]) return j;
    end
`endif
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic post_req(input int id, input bit we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] e);
    we_a[id]    = we;
    addr_a[id]  = a;
    wdata_a[id] = d;
    exp_a[id]   = e;
    bus.req_we[id]              = we;
    bus.req_addr[id*AW +: AW]   = a;
    bus.req_wdata[id*DW +: DW]  = d;
    bus.req[id]                 = 1'b1;
  endtask

  // Observe n grants within budget cycles; requesters listed in again[]
  // re-request one cycle after dropping.
  task automatic run_grants(input int n, input int budget);
    int                 got;
    int                 t;
    int                 prev;
    bit                 prev_we;
    int                 w;
    logic [NUM_REQ-1:0] sampled;
    logic [NUM_REQ-1:0] rearm;
    got = 0; t = 0; prev = -1; prev_we = 1'b0; rearm = '0;
    while (got < n && t < budget) begin
      @(posedge clk); #1;
      t++;
      sampled = bus.req;
      bus.req = bus.req | rearm;
      rearm   = '0;
      if (bus.gnt != '0) begin
        w = pick(sampled, last_m);
        check("grant", bus.gnt, onehot(w));
        if (w >= 0) begin
          check("strobes",
                {bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_data_in, bus.busy},
                {we_a[w], !we_a[w], addr_a[w], wdata_a[w], 1'b1});
          if (prev >= 0) check("grant_gap", cyc - prev, prev_we ? 3 : 4);
          sb.push_back('{id: w, we: we_a[w], rdata: exp_a[w],
                         cyc: cyc + (we_a[w] ? 1 : 2)});
          prev    = cyc;
          prev_we = we_a[w];
          last_m  = w;
          got++;
          bus.req[w] = 1'b0;
          if (again[w] > 0) begin
            again[w]--;
            rearm[w] = 1'b1;
          end
        end
      end
    end
    check("grant_count", got, n);
  endtask

  task automatic drain();
    int t;
    t = 0;
    do begin
      @(posedge clk); #1;
      t++;
    end while ((sb.size() != 0 || bus.busy) && t < 20);
    check("drain_idle", {sb.size() == 0, bus.busy}, {1'b1, 1'b0});
  endtask

  task automatic apply_reset();
    reset   = 1'b1;
    bus.req = '0;
    repeat (2) @(posedge clk);
    #1;
    reset   = 1'b0;
    sb.delete();
    last_m  = NUM_REQ - 1;
    last_rd = '0;
  endtask

  // Response monitor: pops the scoreboard on every completion pulse
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset) begin
      if (bus.mem_read || bus.mem_write)
        check("strobe_excl", {bus.mem_read, bus.mem_write} == 2'b11, 1'b0);
      if (bus.rsp_valid != '0) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", bus.rsp_valid, '0);
        end else begin
          e = sb.pop_front();
          check("rsp_id", bus.rsp_valid, onehot(e.id));
          check("rsp_cycle", cyc, e.cyc);
          if (!e.we) begin
            check("rsp_rdata", bus.rsp_rdata, e.rdata);
            last_rd = e.rdata;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{id: 2, we: 1'b1, addr: 5'd5,  wdata: 8'hA5, rdata: 8'h00};
    vt[1] = '{id: 2, we: 1'b0, addr: 5'd5,  wdata: 8'h00, rdata: 8'hA5};
    vt[2] = '{id: 1, we: 1'b1, addr: 5'd31, wdata: 8'hFF, rdata: 8'h00};
    vt[3] = '{id: 0, we: 1'b1, addr: 5'd0,  wdata: 8'h01, rdata: 8'h00};
    vt[4] = '{id: 3, we: 1'b0, addr: 5'd31, wdata: 8'h00, rdata: 8'hFF};
    vt[5] = '{id: 1, we: 1'b0, addr: 5'd0,  wdata: 8'h00, rdata: 8'h01};
    vt[6] = '{id: 0, we: 1'b0, addr: 5'd9,  wdata: 8'h00, rdata: 8'h42};
    vt[7] = '{id: 3, we: 1'b1, addr: 5'd9,  wdata: 8'h3C, rdata: 8'h00};
    vt[8] = '{id: 2, we: 1'b0, addr: 5'd9,  wdata: 8'h00, rdata: 8'h3C};

    for (int a = 0; a < 32; a++) mem[a] = pre(a);
    bus.req = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) again[i] = 0;

    // Reset then idle
    apply_reset();
    repeat (10) begin
      @(posedge clk); #1;
      check("idle_outputs",
            {bus.gnt, bus.rsp_valid, bus.rsp_rdata, bus.busy, bus.mem_read,
             bus.mem_write, bus.mem_addr, bus.mem_data_in}, '0);
    end

    // Single transactions, including address boundaries 0 and 31
    for (int i = 0; i < 9; i++) begin
      post_req(vt[i].id, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].rdata);
      run_grants(1, 1);
      drain();
      if (vt[i].we) check("rdata_hold", bus.rsp_rdata, last_rd);
    end

    // Reset during CAPTURE aborts the read
    post_req(0, 1'b0, 5'd12, 8'h00, pre(12));
    @(posedge clk); #1;
    check("abort_gnt", bus.gnt, 4'b0001);
    bus.req[0] = 1'b0;
    @(posedge clk); #1;
    check("abort_capture", {bus.busy, bus.mem_read, bus.rsp_valid}, {1'b1, 1'b0, 4'b0000});
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_reset",
          {bus.gnt, bus.rsp_valid, bus.rsp_rdata, bus.busy, bus.mem_read,
           bus.mem_write, bus.mem_addr, bus.mem_data_in}, '0);
    reset   = 1'b0;
    last_m  = NUM_REQ - 1;
    last_rd = '0;
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_quiet", {bus.rsp_valid, bus.rsp_rdata, bus.busy}, '0);
    end
    post_req(3, 1'b0, 5'd10, 8'h00, pre(10));
    post_req(0, 1'b0, 5'd13, 8'h00, pre(13));
    run_grants(2, 20);
    drain();

    // Four-way contention after reset
    apply_reset();
    for (int i = 0; i < NUM_REQ; i++) post_req(i, 1'b0, AW'(10 + i), 8'h00, pre(10 + i));
    run_grants(4, 40);
    drain();

    // Requester 0 re-requests repeatedly against a waiting requester 3
    post_req(0, 1'b1, 5'd20, 8'h11, 8'h00);
    post_req(3, 1'b1, 5'd21, 8'h22, 8'h00);
    again[0] = 3;
    run_grants(5, 60);
    drain();
    post_req(1, 1'b0, 5'd20, 8'h00, 8'h11);
    run_grants(1, 1);
    drain();
    post_req(2, 1'b0, 5'd21, 8'h00, 8'h22);
    run_grants(1, 1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter and sequencer that shares the single 32×8 synchronous memory port (read/write/addr/data_in/data_out) among `NUM_REQ` requesters. It accepts one-access requests, grants one requester at a time and drives the memory strobes with a fixed cycle sequence. It returns read data or a write acknowledge to the granted requester. It sits between the memory and the testbench/DMA-style agents that previously drove the memory port directly.

## Interface
- `NUM_REQ`, 4: number of requesters (2–8).
- `AW`, 5: memory address width.
- `DW`, 8: memory data width.

- `clk` in 1: single clock, all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `req` in NUM_REQ: per-requester access request.
- `req_we` in NUM_REQ: 1 = write, 0 = read.
- `req_addr` in NUM_REQ*AW: packed addresses; requester i at bits [i*AW +: AW].
- `req_wdata` in NUM_REQ*DW: packed write data; requester i at bits [i*DW +: DW].
- `gnt` out NUM_REQ: one-hot grant pulse, registered.
- `rsp_valid` out NUM_REQ: one-hot completion pulse, registered.
- `rsp_rdata` out DW: read data, valid with `rsp_valid`.
- `busy` out 1: high whenever the FSM is not IDLE.
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe.
- `mem_addr` out AW: memory address.
- `mem_data_in` out DW: memory write data.
- `mem_data_out` in DW: memory read data. Valid the cycle after the cycle in which `mem_read` is high.

## Operation
- FSM states: IDLE, ACCESS, CAPTURE, DONE.
- **IDLE**
  - If any `req` bit is set, select a winner i (see arbitration).
  - At the next posedge: `gnt[i]`=1; latch i, `req_we[i]`, address and data; drive `mem_addr` and `mem_data_in`; assert `mem_write` (write) or `mem_read` (read); go to ACCESS.
  - With no request, stay in IDLE and hold all strobes at 0.
- **ACCESS** (exactly one cycle, memory samples at its end)
  - Next posedge: `gnt`=0, `mem_read`/`mem_write`=0.
  - Write: set `rsp_valid[i]`=1 and go to DONE.
  - Read: go to CAPTURE.
- **CAPTURE**
  - Next posedge: `rsp_rdata` ← `mem_data_out`, `rsp_valid[i]`=1, go to DONE.
- **DONE**
  - Next posedge: `rsp_valid`=0, go to IDLE.
- Arbitration:
  - Round-robin pointer `last` holds the index of the last granted requester.
  - The search starts at (`last`+1) mod NUM_REQ.
  - `last` updates only when a grant is issued.
- Handshake rules:
  - Requesters hold `req`, `req_we`, `req_addr` and `req_wdata` stable from assertion until they see `gnt`.
  - The command is captured at the grant edge; later changes are ignored.
  - A requester must drop `req` in the cycle after `gnt`. If `req` is still high when the FSM returns to IDLE, it is treated as a new request.
  - A request asserted while the FSM is not IDLE waits. It is never dropped.
- Write transactions leave `rsp_rdata` unchanged. `rsp_rdata` holds its value until the next read completion.
- `mem_read` and `mem_write` are never high together. `mem_addr` and `mem_data_in` hold their last values outside ACCESS.

## Timing
- Reset values: `gnt`=0, `rsp_valid`=0, `rsp_rdata`=0, `busy`=0, `mem_read`=0, `mem_write`=0, `mem_addr`=0, `mem_data_in`=0. State is IDLE and `last`=NUM_REQ-1, so requester 0 wins first.
- Let `req` be sampled high in IDLE at edge T. Then:
  - `gnt` and the memory strobe are high for cycle T+1.
  - Write: `rsp_valid` is high for cycle T+2, and the FSM is in IDLE at T+3.
  - Read: `rsp_valid` and `rsp_rdata` are valid for cycle T+3, and the FSM is in IDLE at T+4.
- Back-to-back throughput with `req` held: one write per 3 cycles, one read per 4 cycles.
- Simultaneous requests: exactly one grant per IDLE visit. No requester waits more than NUM_REQ-1 grants (round-robin mode).
- Reset asserted in any state: all outputs return to reset values at that edge. The in-flight access is aborted with no `rsp_valid`, and `last` is reinitialised.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration as described above.
- `MEM_ARB_RR_EN` undefined:
  - Fixed priority; the lowest index wins.
  - The `last` register is removed.
  - All other timing and handshake behaviour is unchanged.

## Test plan
- Reset then idle: no `req` for 10 cycles → all outputs 0, `busy`=0 throughout.
- Single write then read:
  - Requester 2 writes addr 5, data 0xA5 → `gnt[2]` at T+1, `mem_write`=1 with `mem_addr`=5 and `mem_data_in`=0xA5, `rsp_valid[2]` at T+2.
  - Requester 2 then reads addr 5 → `rsp_rdata`=0xA5 with `rsp_valid[2]` at T+3.
- Contention (`MEM_ARB_RR_EN` defined): all four requesters read distinct addresses, each `req` held until its `gnt` → grant order 0, 1, 2, 3, each `rsp_rdata` matching preloaded memory contents.
- Fixed priority (macro undefined): requesters 0 and 3 re-request continuously → requester 3 is never granted. Drop requester 0's requests → requester 3 granted next.
- Reset mid-read: assert `reset` during CAPTURE → no `rsp_valid` pulse. The next request is granted to requester 0, and `rsp_rdata`=0 until that read completes.
- Address boundary: write 0xFF to addr 31 and 0x01 to addr 0, then read both → 0xFF and 0x01 returned, no aliasing.
